// File: rtl/ltpi_gpio_pkg.sv
// Shared constants and sizing helpers for the LTPI GPIO tunneling channel.
package ltpi_gpio_pkg;

    localparam int LTPI_NUM_LL_GPIO_DEF = 16;
    localparam int LTPI_NUM_NL_GPIO_DEF = 128;
    localparam int LTPI_NL_CHUNK_W_DEF  = 8;

    function automatic int ltpi_chunk_count(input int num_nl, input int chunk_w);
        return num_nl / chunk_w;
    endfunction

    // Index width never collapses to zero, even with a single chunk.
    function automatic int ltpi_idx_w(input int num_nl, input int chunk_w);
        int chunks;
        chunks = ltpi_chunk_count(num_nl, chunk_w);
        return (chunks > 1) ? $clog2(chunks) : 1;
    endfunction

endpackage

// File: rtl/ltpi_gpio_sync.sv
// Parameterized-width two-flop synchronizer, reset to zero.
module ltpi_gpio_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two register stages to resolve metastability on asynchronous pins.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= {WIDTH{1'b0}};
            sync_q <= {WIDTH{1'b0}};
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/ltpi_gpio.sv
// LTPI GPIO tunneling: LL GPIOs every frame, NL GPIOs one chunk per frame.
// Optional input synchronizers are enabled with LTPI_GPIO_INPUT_SYNC_EN.
module ltpi_gpio
    import ltpi_gpio_pkg::*;
#(
    parameter int NUM_LL_GPIO = LTPI_NUM_LL_GPIO_DEF,
    parameter int NUM_NL_GPIO = LTPI_NUM_NL_GPIO_DEF,
    parameter int NL_CHUNK_W  = LTPI_NL_CHUNK_W_DEF,
    parameter int IDX_W       = ltpi_idx_w(NUM_NL_GPIO, NL_CHUNK_W)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   link_up,
    input  logic                   frame_tick,
    input  logic [NUM_LL_GPIO-1:0] ll_gpio_in,
    input  logic [NUM_NL_GPIO-1:0] nl_gpio_in,
    output logic [NUM_LL_GPIO-1:0] tx_ll_gpio,
    output logic [IDX_W-1:0]       tx_nl_idx,
    output logic [NL_CHUNK_W-1:0]  tx_nl_data,
    output logic                   tx_nl_wrap,
    input  logic                   rx_valid,
    input  logic [NUM_LL_GPIO-1:0] rx_ll_gpio,
    input  logic [IDX_W-1:0]       rx_nl_idx,
    input  logic [NL_CHUNK_W-1:0]  rx_nl_data,
    output logic [NUM_LL_GPIO-1:0] ll_gpio_out,
    output logic [NUM_NL_GPIO-1:0] nl_gpio_out
);

    localparam int              NUM_CHUNKS = ltpi_chunk_count(NUM_NL_GPIO, NL_CHUNK_W);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_CHUNKS - 1);

    logic [NUM_LL_GPIO-1:0] ll_s;
    logic [NUM_NL_GPIO-1:0] nl_s;

`ifdef LTPI_GPIO_INPUT_SYNC_EN
    ltpi_gpio_sync #(.WIDTH(NUM_LL_GPIO)) u_sync_ll (
        .clk_i   (clk),
        .rst_n_i (reset_n),
        .d_i     (ll_gpio_in),
        .q_o     (ll_s)
    );
    ltpi_gpio_sync #(.WIDTH(NUM_NL_GPIO)) u_sync_nl (
        .clk_i   (clk),
        .rst_n_i (reset_n),
        .d_i     (nl_gpio_in),
        .q_o     (nl_s)
    );
`else
    assign ll_s = ll_gpio_in;
    assign nl_s = nl_gpio_in;
`endif

    logic [IDX_W-1:0]       idx_q,     idx_d;
    logic [NUM_LL_GPIO-1:0] tx_ll_q,   tx_ll_d;
    logic [IDX_W-1:0]       tx_idx_q,  tx_idx_d;
    logic [NL_CHUNK_W-1:0]  tx_data_q, tx_data_d;
    logic                   tx_wrap_q, tx_wrap_d;
    logic [NUM_LL_GPIO-1:0] ll_out_q,  ll_out_d;
    logic [NUM_NL_GPIO-1:0] nl_out_q,  nl_out_d;

    // Next-state: link-down clear dominates; TX and RX are serviced independently.
    always_comb begin
        idx_d     = idx_q;
        tx_ll_d   = tx_ll_q;
        tx_idx_d  = tx_idx_q;
        tx_data_d = tx_data_q;
        tx_wrap_d = 1'b0;
        ll_out_d  = ll_out_q;
        nl_out_d  = nl_out_q;
        if (!link_up) begin
            idx_d     = {IDX_W{1'b0}};
            tx_ll_d   = {NUM_LL_GPIO{1'b0}};
            tx_idx_d  = {IDX_W{1'b0}};
            tx_data_d = {NL_CHUNK_W{1'b0}};
            ll_out_d  = {NUM_LL_GPIO{1'b0}};
            nl_out_d  = {NUM_NL_GPIO{1'b0}};
        end else begin
            if (frame_tick) begin
                tx_ll_d   = ll_s;
                tx_idx_d  = idx_q;
                tx_data_d = nl_s[idx_q * NL_CHUNK_W +: NL_CHUNK_W];
                tx_wrap_d = (idx_q == LAST_IDX);
                idx_d     = (idx_q == LAST_IDX) ? {IDX_W{1'b0}} : idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
            end else begin
                idx_d = idx_q;
            end
            if (rx_valid) begin
                ll_out_d = rx_ll_gpio;
                // Out-of-range chunk indices only update the LL field.
                if (32'(rx_nl_idx) < NUM_CHUNKS) begin
                    nl_out_d[rx_nl_idx * NL_CHUNK_W +: NL_CHUNK_W] = rx_nl_data;
                end else begin
                    nl_out_d = nl_out_q;
                end
            end else begin
                ll_out_d = ll_out_q;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx_q     <= {IDX_W{1'b0}};
            tx_ll_q   <= {NUM_LL_GPIO{1'b0}};
            tx_idx_q  <= {IDX_W{1'b0}};
            tx_data_q <= {NL_CHUNK_W{1'b0}};
            tx_wrap_q <= 1'b0;
            ll_out_q  <= {NUM_LL_GPIO{1'b0}};
            nl_out_q  <= {NUM_NL_GPIO{1'b0}};
        end else begin
            idx_q     <= idx_d;
            tx_ll_q   <= tx_ll_d;
            tx_idx_q  <= tx_idx_d;
            tx_data_q <= tx_data_d;
            tx_wrap_q <= tx_wrap_d;
            ll_out_q  <= ll_out_d;
            nl_out_q  <= nl_out_d;
        end
    end

    assign tx_ll_gpio  = tx_ll_q;
    assign tx_nl_idx   = tx_idx_q;
    assign tx_nl_data  = tx_data_q;
    assign tx_nl_wrap  = tx_wrap_q;
    assign ll_gpio_out = ll_out_q;
    assign nl_gpio_out = nl_out_q;

endmodule

// File: tb/tb_ltpi_gpio.sv
// Directed plus randomized bench for ltpi_gpio with a frame-level reference model.
module tb_ltpi_gpio;

    localparam int NLL    = 16;
    localparam int NNL    = 128;
    localparam int CW     = 8;
    localparam int NCH    = NNL / CW;
    localparam int IW     = 4;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           link_up;
    logic           frame_tick;
    logic [NLL-1:0] ll_gpio_in;
    logic [NNL-1:0] nl_gpio_in;
    logic [NLL-1:0] tx_ll_gpio;
    logic [IW-1:0]  tx_nl_idx;
    logic [CW-1:0]  tx_nl_data;
    logic           tx_nl_wrap;
    logic           rx_valid;
    logic [NLL-1:0] rx_ll_gpio;
    logic [IW-1:0]  rx_nl_idx;
    logic [CW-1:0]  rx_nl_data;
    logic [NLL-1:0] ll_gpio_out;
    logic [NNL-1:0] nl_gpio_out;

    int tests = 0;
    int fails = 0;

    // Reference model: frames sent since link came up, plus a per-chunk mirror.
    int             m_frames;
    logic [NLL-1:0] m_tx_ll;
    int             m_tx_idx;
    logic [CW-1:0]  m_tx_data;
    logic           m_wrap;
    logic [NLL-1:0] m_ll_out;
    logic [CW-1:0]  m_chunk [NCH];

    ltpi_gpio dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .link_up     (link_up),
        .frame_tick  (frame_tick),
        .ll_gpio_in  (ll_gpio_in),
        .nl_gpio_in  (nl_gpio_in),
        .tx_ll_gpio  (tx_ll_gpio),
        .tx_nl_idx   (tx_nl_idx),
        .tx_nl_data  (tx_nl_data),
        .tx_nl_wrap  (tx_nl_wrap),
        .rx_valid    (rx_valid),
        .rx_ll_gpio  (rx_ll_gpio),
        .rx_nl_idx   (rx_nl_idx),
        .rx_nl_data  (rx_nl_data),
        .ll_gpio_out (ll_gpio_out),
        .nl_gpio_out (nl_gpio_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [NNL-1:0] obs, input logic [NNL-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [NNL-1:0] model_nl();
        logic [NNL-1:0] v;
        v = '0;
        for (int k = 0; k < NCH; k++) v = v | ({{(NNL-CW){1'b0}}, m_chunk[k]} << (k * CW));
        return v;
    endfunction

    task automatic model_clear();
        m_frames = 0; m_tx_ll = '0; m_tx_idx = 0; m_tx_data = '0; m_wrap = 1'b0; m_ll_out = '0;
        for (int k = 0; k < NCH; k++) m_chunk[k] = '0;
    endtask

    task automatic model_update();
        int k;
        if (!link_up) begin
            model_clear();
        end else begin
            m_wrap = 1'b0;
            if (frame_tick) begin
                k         = m_frames % NCH;
                m_tx_idx  = k;
                m_tx_ll   = ll_gpio_in;
                m_tx_data = CW'(nl_gpio_in >> (k * CW));
                m_wrap    = (k == NCH - 1);
                m_frames++;
            end
            if (rx_valid) begin
                m_ll_out = rx_ll_gpio;
                if (int'(rx_nl_idx) < NCH) m_chunk[rx_nl_idx] = rx_nl_data;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".tx_ll"},   NNL'(tx_ll_gpio),  NNL'(m_tx_ll));
        check({tag, ".tx_idx"},  NNL'(tx_nl_idx),   NNL'(m_tx_idx));
        check({tag, ".tx_data"}, NNL'(tx_nl_data),  NNL'(m_tx_data));
        check({tag, ".wrap"},    NNL'(tx_nl_wrap),  NNL'(m_wrap));
        check({tag, ".ll_out"},  NNL'(ll_gpio_out), NNL'(m_ll_out));
        check({tag, ".nl_out"},  nl_gpio_out,       model_nl());
    endtask

    task automatic step(input string tag, input logic lk, input logic ft, input logic rv);
        link_up = lk; frame_tick = ft; rx_valid = rv;
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        reset_n = 1'b0; link_up = 1'b0; frame_tick = 1'b0; rx_valid = 1'b0;
        ll_gpio_in = '0; nl_gpio_in = '0; rx_ll_gpio = '0; rx_nl_idx = '0; rx_nl_data = '0;
        model_clear();
        repeat (3) @(negedge clk);
        check_all("reset");
        reset_n = 1'b1;

        // Link down: ticks and rx strobes must be ignored.
        for (int i = 0; i < 6; i++) begin
            ll_gpio_in = 16'($urandom); nl_gpio_in = {4{$urandom}};
            rx_ll_gpio = 16'($urandom); rx_nl_idx = 4'($urandom); rx_nl_data = 8'($urandom);
            step("link_down", 1'b0, 1'(i), 1'(~i));
        end

        // Full refresh with chunk k carrying value k, then one more tick for wrap.
        for (int k = 0; k < NCH; k++) nl_gpio_in[k*CW +: CW] = CW'(k);
        for (int i = 0; i <= NCH; i++) begin
            ll_gpio_in = 16'($urandom);
            step("refresh", 1'b1, 1'b1, 1'b0);
            if (i == NCH - 1) check("wrap_last", NNL'(tx_nl_wrap), NNL'(1'b1));
            if (i == NCH)     check("idx_after_wrap", NNL'(tx_nl_idx), NNL'(0));
        end

        ll_gpio_in = 16'hA5C3;
        step("ll_sample", 1'b1, 1'b1, 1'b0);
        check("ll_a5c3", NNL'(tx_ll_gpio), NNL'(16'hA5C3));

        rx_ll_gpio = 16'h1234; rx_nl_idx = 4'd3; rx_nl_data = 8'hFF;
        step("rx3", 1'b1, 1'b0, 1'b1);
        check("rx3_chunk", NNL'(nl_gpio_out[31:24]), NNL'(8'hFF));
        check("rx3_ll", NNL'(ll_gpio_out), NNL'(16'h1234));

        rx_ll_gpio = 16'hBEEF; rx_nl_idx = 4'd7; rx_nl_data = 8'h5A;
        step("drop_rx", 1'b0, 1'b1, 1'b1);
        check("drop_nl_zero", nl_gpio_out, '0);

        // Link back up: first tick sends chunk 0; concurrent RX also applied.
        nl_gpio_in = {4{$urandom}}; ll_gpio_in = 16'($urandom);
        rx_ll_gpio = 16'h0F0F; rx_nl_idx = 4'd15; rx_nl_data = 8'hC3;
        step("both", 1'b1, 1'b1, 1'b1);
        check("both_idx0", NNL'(tx_nl_idx), NNL'(0));
        check("both_chunk15", NNL'(nl_gpio_out[127:120]), NNL'(8'hC3));

        for (int i = 0; i < 300; i++) begin
            ll_gpio_in = 16'($urandom); nl_gpio_in = {$urandom, $urandom, $urandom, $urandom};
            rx_ll_gpio = 16'($urandom); rx_nl_idx = 4'($urandom); rx_nl_data = 8'($urandom);
            step("random", ($urandom_range(0, 15) != 0), 1'($urandom), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ltpi_gpio.md
# ltpi_gpio

GPIO tunneling channel for the LTPI (LVDS Tunneling Protocol & Interface) link of the DC-SCM design. It samples local low-latency (LL) GPIOs every frame and time-multiplexes a wide normal-latency (NL) GPIO vector into fixed-size chunks, one chunk per frame, toward the frame encoder. On the receive side it applies decoded LL GPIOs and NL chunks to registered outputs. It sits between the board GPIO pins and the LTPI frame TX/RX datapath.

## Interface
- NUM_LL_GPIO, 16, LL GPIO count; all carried in every frame.
- NUM_NL_GPIO, 128, NL GPIO count; must be a multiple of NL_CHUNK_W.
- NL_CHUNK_W, 8, NL bits carried per frame.
- IDX_W, derived as $clog2(NUM_NL_GPIO/NL_CHUNK_W), minimum 1; chunk index width.
- clk  in  1  single clock domain for the block.
- reset_n  in  1  asynchronous, active-low reset.
- link_up  in  1  LTPI link operational; gates all TX/RX activity.
- frame_tick  in  1  one-cycle strobe at each TX frame boundary.
- ll_gpio_in  in  NUM_LL_GPIO  local LL GPIO inputs.
- nl_gpio_in  in  NUM_NL_GPIO  local NL GPIO inputs.
- tx_ll_gpio  out  NUM_LL_GPIO  LL field of the next TX frame.
- tx_nl_idx  out  IDX_W  NL chunk index of the next TX frame.
- tx_nl_data  out  NL_CHUNK_W  NL chunk data of the next TX frame.
- tx_nl_wrap  out  1  one-cycle pulse when the last chunk is loaded.
- rx_valid  in  1  one-cycle strobe: decoded frame, CRC good.
- rx_ll_gpio  in  NUM_LL_GPIO  received LL field.
- rx_nl_idx  in  IDX_W  received NL chunk index.
- rx_nl_data  in  NL_CHUNK_W  received NL chunk data.
- ll_gpio_out  out  NUM_LL_GPIO  remote LL GPIO values.
- nl_gpio_out  out  NUM_NL_GPIO  remote NL GPIO values.

## Operation
- TX: on frame_tick && link_up: tx_ll_gpio <= ll_gpio_in; tx_nl_data <= nl_gpio_in[idx*NL_CHUNK_W +: NL_CHUNK_W]; tx_nl_idx <= idx; idx increments, wraps to 0 after chunk NUM_NL_GPIO/NL_CHUNK_W-1; tx_nl_wrap pulses in the cycle the last chunk is loaded.
- RX: on rx_valid && link_up: ll_gpio_out <= rx_ll_gpio; nl_gpio_out chunk rx_nl_idx <= rx_nl_data; other chunks hold. An rx_nl_idx >= chunk count is ignored for NL; LL is still applied.
- Link down (link_up=0): idx forced to 0; all tx_* outputs and ll_gpio_out/nl_gpio_out forced to 0 the next cycle, held while down. frame_tick and rx_valid are ignored.
- Reset: every output 0, idx 0.

## Timing
- All outputs registered; 1-cycle latency from frame_tick or rx_valid to output update.
- frame_tick and rx_valid in the same cycle: both are serviced independently.
- link_up falling in the same cycle as frame_tick or rx_valid: link-down clear wins.
- After link_up rises, the first frame_tick sends chunk 0.
- A full NL refresh takes NUM_NL_GPIO/NL_CHUNK_W frames (16 at defaults).

## Configuration
- LTPI_GPIO_INPUT_SYNC_EN defined: ll_gpio_in and nl_gpio_in pass through a 2-flop synchronizer, reset to 0, before sampling. This adds 2 cycles from pin change to sample eligibility.
- Not defined: inputs are sampled directly and are assumed synchronous to clk.

## Structure
- Package ltpi_gpio_pkg: default parameter constants and a chunk-count helper function.
- Sub-module ltpi_gpio_sync: a parameterized-width 2-flop synchronizer, instantiated only under LTPI_GPIO_INPUT_SYNC_EN.

## Test plan
- Reset, then link_up=0 with frame_tick and rx_valid toggling -> all outputs 0, tx_nl_idx stays 0.
- link_up=1, nl_gpio_in=128'h0F0E..0100 (chunk k = k), 16 frame_ticks -> tx_nl_idx 0..15, tx_nl_data=idx, tx_nl_wrap on the 16th, 17th tick gives idx 0.
- ll_gpio_in=16'hA5C3, frame_tick -> tx_ll_gpio=16'hA5C3 one cycle later.
- rx_valid with rx_ll_gpio=16'h1234, rx_nl_idx=3, rx_nl_data=8'hFF -> ll_gpio_out=16'h1234, nl_gpio_out[31:24]=8'hFF, other bits unchanged.
- link_up drops in the same cycle as rx_valid -> outputs 0 next cycle, received data discarded.
- frame_tick and rx_valid in the same cycle -> TX chunk advances and RX update both applied.
